seq_bit_conditioner: RTL

//  Upstream input stage for the serial sequence detector and its 7-segment display path.
//  - Turns a raw, bouncing push-button (btn_raw) plus a raw data switch (data_raw) into clean serial bits.
//  - Each debounced press emits exactly one bit_out/bit_valid pair; the detector consumes it as x,

---
 rtl/seq_cond_pkg.sv | 13 +
 rtl/seq_sync.sv | 20 ++
 rtl/seq_bit_conditioner.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/seq_cond_pkg.sv
// Shared state type and widths for the serial bit conditioner.
package seq_cond_pkg;

   localparam int BIT_COUNT_W = 8;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DB_PRESS   = 2'd1,
      HELD       = 2'd2,
      DB_RELEASE = 2'd3
   } state_t;

endpackage

// File: rtl/seq_sync.sv
// N-flop synchronizer for one asynchronous input, with async active-low clear.
module seq_sync #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [N-1:0] ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ff <= '0;
      else        ff <= {ff[N-2:0], d};
   end

   assign q = ff[N-1];

endmodule

// File: rtl/seq_bit_conditioner.sv
// Debounces a push-button and emits one data bit per accepted press.
// Optional auto-repeat while held: define SEQ_COND_AUTOREPEAT_EN.
module seq_bit_conditioner
   import seq_cond_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_CYCLES   = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ena,
   input  logic                   btn_raw,
   input  logic                   data_raw,
   output logic                   bit_out,
   output logic                   bit_valid,
   output logic                   busy,
   output logic [BIT_COUNT_W-1:0] bit_count
);

   localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_chk
      $error("seq_bit_conditioner: SYNC_STAGES, DEBOUNCE_CYCLES, REPEAT_CYCLES must be >= 2");
   end

   logic btn_s, data_s;

   seq_sync #(.N(SYNC_STAGES)) u_sync_btn (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (btn_raw),
      .q     (btn_s)
   );

   seq_sync #(.N(SYNC_STAGES)) u_sync_data (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (data_raw),
      .q     (data_s)
   );

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             emit;

`ifdef SEQ_COND_AUTOREPEAT_EN
   localparam int               RPT_W   = $clog2(REPEAT_CYCLES);
   localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);
   logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

   // State register and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
`ifdef SEQ_COND_AUTOREPEAT_EN
         rpt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
`ifdef SEQ_COND_AUTOREPEAT_EN
         rpt_q   <= rpt_d;
`endif
      end
   end

   // Next state; emit marks the edge that captures a new bit
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      emit    = 1'b0;
      if (!ena) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (btn_s) begin
                  state_d = DB_PRESS;
                  cnt_d   = '0;
               end
            end
            DB_PRESS: begin
               if (!btn_s) begin
                  state_d = IDLE;
               end else if (cnt_q == CNT_MAX) begin
                  state_d = HELD;
                  emit    = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            HELD: begin
               if (!btn_s) begin
                  state_d = DB_RELEASE;
                  cnt_d   = '0;
               end
            end
            DB_RELEASE: begin
               if (btn_s) begin
                  state_d = HELD;
               end else if (cnt_q == CNT_MAX) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end

`ifdef SEQ_COND_AUTOREPEAT_EN
      // Repeat timer only runs across consecutive HELD cycles; any other path restarts it.
      rpt_d = rpt_q;
      if (!ena || state_q != HELD || state_d != HELD) begin
         rpt_d = '0;
      end else if (rpt_q == RPT_MAX) begin
         rpt_d = '0;
         emit  = 1'b1;
      end else begin
         rpt_d = rpt_q + 1'b1;
      end
`endif
   end

   // Outputs
   always_comb begin
      busy = (state_q != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_valid <= 1'b0;
         bit_out   <= 1'b0;
         bit_count <= '0;
      end else begin
         bit_valid <= emit;
         if (emit) begin
            bit_out   <= data_s;
            bit_count <= bit_count + 1'b1;
         end
      end
   end

endmodule
